// File: rtl/sram_bus_arbiter_if.sv
// External SRAM bus: the arbiter drives it as master, the memory port answers as slave.
interface sram_bus_arbiter_if;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        bus_err_o;

   modport master (
      output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o,
      input  bus_rdata_i, bus_ack_i
   );

   modport slave (
      input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o,
      output bus_rdata_i, bus_ack_i
   );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM port between the IF and MEM requesters (MEM has fixed priority).
// Define ARB_TIMEOUT_EN to add a bus watchdog that aborts unanswered requests.
module sram_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ce_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   output logic        if_stallreq_o,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] mem_data_o,
   output logic        mem_stallreq_o,
   input  logic        stall_i,
   input  logic        flush_i,
   sram_bus_arbiter_if.master bus
);
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   typedef enum logic [1:0] {IDLE = 2'd0, IF_BUSY = 2'd1, MEM_BUSY = 2'd2} state_e;

   state_e          state_q, state_d;
   logic            if_valid_q, mem_valid_q, discard_q;
   logic            busy, done, timeout, discard;
   logic            grant_if, grant_mem, if_done, mem_done;
   logic            req_q, we_q;
   logic [DW-1:0]   addr_q, wdata_q, if_data_q, mem_data_q;
   logic [SW-1:0]   sel_q;

   assign busy    = (state_q != IDLE);
   assign done    = busy & (bus.bus_ack_i | timeout);
   // A flush on the completing edge itself must also suppress the result.
   assign discard = discard_q | flush_i;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= timeout;
         if (!busy)
            cnt_q <= '0;
         else if (!bus.bus_ack_i)
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign timeout       = busy & ~bus.bus_ack_i & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign bus.bus_err_o = err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
   assign bus.bus_err_o      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (mem_ce_i && !mem_valid_q)     state_d = MEM_BUSY;
            else if (if_ce_i && !if_valid_q)  state_d = IF_BUSY;
         end
         IF_BUSY, MEM_BUSY: if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_mem = 1'b0;
      grant_if  = 1'b0;
      if_done   = 1'b0;
      mem_done  = 1'b0;
      case (state_q)
         IDLE: begin
            grant_mem = (state_d == MEM_BUSY);
            grant_if  = (state_d == IF_BUSY);
         end
         IF_BUSY:  if_done  = done;
         MEM_BUSY: mem_done = done;
         default: ;
      endcase
   end

   // Bus command registers are held stable for the whole transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         sel_q   <= '0;
         wdata_q <= '0;
      end else if (grant_mem) begin
         req_q   <= 1'b1;
         we_q    <= mem_we_i;
         addr_q  <= mem_addr_i;
         sel_q   <= mem_sel_i;
         wdata_q <= mem_wdata_i;
      end else if (grant_if) begin
         req_q   <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= if_addr_i;
         sel_q   <= '1;
      end else if (done) begin
         req_q   <= 1'b0;
      end
   end

   // Buffers update even for discarded results; only the valid flag is withheld.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_data_q  <= '0;
         mem_data_q <= '0;
      end else begin
         if (if_done)
            if_data_q <= timeout ? '0 : bus.bus_rdata_i;
         if (mem_done && (timeout || !we_q))
            mem_data_q <= timeout ? '0 : bus.bus_rdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         discard_q   <= 1'b0;
      end else begin
         if (if_done && !discard)         if_valid_q <= 1'b1;
         else if (!stall_i || flush_i)    if_valid_q <= 1'b0;

         if (mem_done && !discard)        mem_valid_q <= 1'b1;
         else if (!stall_i || flush_i)    mem_valid_q <= 1'b0;

         if (done)                        discard_q <= 1'b0;
         else if (busy && flush_i)        discard_q <= 1'b1;
      end
   end

   assign if_stallreq_o   = if_ce_i & ~if_valid_q;
   assign mem_stallreq_o  = mem_ce_i & ~mem_valid_q;
   assign if_data_o       = if_data_q;
   assign mem_data_o      = mem_data_q;
   assign bus.bus_req_o   = req_q;
   assign bus.bus_we_o    = we_q;
   assign bus.bus_addr_o  = addr_q;
   assign bus.bus_sel_o   = sel_q;
   assign bus.bus_wdata_o = wdata_q;
endmodule
